sar_search: RTL



---
 rtl/sar_search.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
// Module  : sar_search
// Purpose : Successive-approximation search controller. It drives the B side
//           of an external magnitude comparator and binary-searches MSB-first
//           for the value on the comparator's A side. The search exits early
//           when the comparator reports equality.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           start               - begin a search (sampled only in IDLE)
//           trial [WIDTH]       - registered code driven to comparator B
//           A_less_B/A_equal_B/A_greater_B - comparator result inputs
//           busy                - high while searching
//           done                - one-cycle completion pulse
//           result [WIDTH]      - final code, held until the next search ends
//           found / err         - equality seen / aborted on a bad compare
// Revision: 1.0 - initial release
// ============================================================================
module sar_search #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             A_less_B,
  input  logic             A_equal_B,
  input  logic             A_greater_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  // A zero-wait configuration still needs a 1-bit counter to keep widths legal.
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [KW-1:0]    k;
  logic [CW-1:0]    settle_cnt;

  logic             sample;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_bad;
  logic [WIDTH-1:0] acc_upd;

  // The comparator is only looked at on the final cycle of each trial window.
  assign sample  = (state == RUN) && (settle_cnt == '0);

  // Only a strictly one-hot compare is meaningful; anything else aborts.
  assign cmp_lt  =  A_less_B & ~A_equal_B & ~A_greater_B;
  assign cmp_eq  = ~A_less_B &  A_equal_B & ~A_greater_B;
  assign cmp_gt  = ~A_less_B & ~A_equal_B &  A_greater_B;
  assign cmp_bad = ~(cmp_lt | cmp_eq | cmp_gt);

  // Target above the trial means the tested bit belongs in the answer.
  assign acc_upd = cmp_gt ? trial : acc;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (sample && (cmp_eq || cmp_bad || (k == '0))) state_next = DONE;
      DONE: state_next = IDLE;   // always pass through IDLE before a new start
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trial      <= '0;
      acc        <= '0;
      k          <= '0;
      settle_cnt <= '0;
      result     <= '0;
      found      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          trial <= '0;
          if (start) begin
            acc        <= '0;
            found      <= 1'b0;
            err        <= 1'b0;
            k          <= KW'(WIDTH - 1);
            trial      <= MSB;
            settle_cnt <= CW'(SETTLE);
          end
        end
        RUN: begin
          if (!sample) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else if (cmp_eq) begin
            result <= trial;
            found  <= 1'b1;
            trial  <= '0;
          end else if (cmp_bad) begin
            result <= acc;
            err    <= 1'b1;
            trial  <= '0;
          end else begin
            acc <= acc_upd;
            if (k == '0) begin
              result <= acc_upd;
              trial  <= '0;
            end else begin
              k          <= k - 1'b1;
              trial      <= acc_upd | (ONE << (k - 1'b1));
              settle_cnt <= CW'(SETTLE);
            end
          end
        end
        DONE: trial <= '0;
        default: trial <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire
